// File: rtl/counter_pkg.sv
// ============================================================================
//  counter_pkg : end-of-range mode encodings and parameter legality helpers
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_calc.sv
// ============================================================================
//  counter_next_calc : combinational next-count and range-event resolution
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module counter_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt,
    output logic             bound_hit
);

    logic [WIDTH:0] w_cnt;
    logic [WIDTH:0] w_lim;
    logic [WIDTH:0] w_stp;
    logic [WIDTH:0] w_span;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_next;
    logic           w_is_wrap;
    logic           w_unused_msb;

    // One extra bit keeps limit+1 and count+step exact even at full width.
    assign w_cnt     = {1'b0, count};
    assign w_lim     = {1'b0, limit};
    assign w_stp     = (step > limit) ? w_lim : {1'b0, step};
    assign w_span    = w_lim + 1'b1;
    assign w_sum     = w_cnt + w_stp;
    assign w_is_wrap = (mode == MODE_WRAP);

    always_comb begin
        w_next    = w_cnt;
        wrap_evt  = 1'b0;
        bound_hit = 1'b0;
        if (limit == '0) begin
            // Single-value range: every step leaves and re-enters at 0.
            w_next    = '0;
            wrap_evt  = w_is_wrap;
            bound_hit = !w_is_wrap;
        end else if (count > limit) begin
            if (!up_down) begin
                w_next = w_lim;
            end else if (mode == MODE_SAT) begin
                w_next    = w_lim;
                bound_hit = 1'b1;
            end else begin
                w_next   = '0;
                wrap_evt = w_is_wrap;
            end
        end else if (up_down) begin
            if (w_sum > w_lim) begin
                if (w_is_wrap) begin
                    w_next   = w_sum - w_span;
                    wrap_evt = 1'b1;
                end else begin
                    w_next    = w_lim;
                    bound_hit = 1'b1;
                end
            end else begin
                w_next    = w_sum;
                bound_hit = (w_sum == w_lim) && !w_is_wrap;
            end
        end else begin
            if (w_stp <= w_cnt) begin
                w_next    = w_cnt - w_stp;
                bound_hit = (w_cnt == w_stp) && !w_is_wrap;
            end else if (w_is_wrap) begin
                w_next   = w_cnt + w_span - w_stp;
                wrap_evt = 1'b1;
            end else begin
                w_next    = '0;
                bound_hit = 1'b1;
            end
        end
    end

    assign next_count   = w_next[WIDTH-1:0];
    assign w_unused_msb = w_next[WIDTH];

endmodule

`default_nettype wire

// File: rtl/counter_mod.sv
// ============================================================================
//  counter_mod : up/down counter with limit, step, wrap/saturate/one-shot
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             wrapped,
    output logic             sat,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_RST_COUNT = WIDTH'(RST_VAL);

    if (!(width_ok(WIDTH) && (64'(RST_VAL) < (64'd1 << WIDTH)))) begin : g_param_check
        $error("counter_mod: WIDTH must be 2..32 and RST_VAL must fit in WIDTH bits");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic             r_sat;
    logic             r_done;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_evt;
    logic             w_bound_hit;
    logic [WIDTH-1:0] w_load_val;
    logic             w_frozen;

    counter_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .count      (r_count),
        .limit      (limit),
        .step       (step),
        .up_down    (up_down),
        .mode       (mode),
        .next_count (w_next),
        .wrap_evt   (w_wrap_evt),
        .bound_hit  (w_bound_hit)
    );

    assign w_load_val = (set > limit) ? limit : set;
    // A finished one-shot stays put until load or reset, whatever the mode.
    assign w_frozen   = (step == '0) || (mode == MODE_HOLD) || r_done;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_count   <= c_RST_COUNT;
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
            r_done    <= 1'b0;
        end else if (load) begin
            r_count   <= w_load_val;
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
            r_done    <= 1'b0;
        end else if (enable && !w_frozen) begin
            r_count   <= w_next;
            r_wrapped <= w_wrap_evt;
            r_sat     <= w_bound_hit && (mode == MODE_SAT);
            r_done    <= w_bound_hit && (mode == MODE_ONESHOT);
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign count   = r_count;
    assign wrapped = r_wrapped;
    assign sat     = r_sat;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_counter_mod.sv
// ============================================================================
//  tb_counter_mod : directed vectors, expectations queued and checked by monitor
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_counter_mod;

    logic       clk;
    logic       res_n;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] set;
    logic [3:0] limit;
    logic [3:0] step;
    logic [1:0] mode;
    logic [3:0] count;
    logic       wrapped;
    logic       sat;
    logic       done;

    typedef struct {
        logic [3:0] c;
        logic       w;
        logic       s;
        logic       d;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_mod #(
        .WIDTH   (4),
        .RST_VAL (0)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .enable  (enable),
        .up_down (up_down),
        .load    (load),
        .set     (set),
        .limit   (limit),
        .step    (step),
        .mode    (mode),
        .count   (count),
        .wrapped (wrapped),
        .sat     (sat),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_now(input logic [3:0] c, input logic w, input logic s,
                              input logic d, input string name);
        exp_t e;
        e.c = c; e.w = w; e.s = s; e.d = d; e.name = name;
        exp_q.push_back(e);
    endtask

    // Drive one edge's controls, then queue the state expected after that edge.
    task automatic cyc(input logic ld, input logic en, input logic [3:0] sv,
                       input logic [3:0] c, input logic w, input logic s,
                       input logic d, input string name);
        @(negedge clk);
        load   = ld;
        enable = en;
        set    = sv;
        @(posedge clk);
        #1;
        expect_now(c, w, s, d, name);
    endtask

    // Monitor: outputs are registered, so they are presented at every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({count, wrapped, sat, done} !== {e.c, e.w, e.s, e.d}) begin
                    n_bad++;
                    $display("FAIL %s: got count=%0d wrapped=%b sat=%b done=%b, want count=%0d wrapped=%b sat=%b done=%b",
                             e.name, count, wrapped, sat, done, e.c, e.w, e.s, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        set = 4'd0; limit = 4'd9; step = 4'd3; mode = 2'b00;
        expect_now(4'd0, 1'b0, 1'b0, 1'b0, "reset");
        @(negedge clk);
        res_n = 1'b1;

        // Wrap up
        cyc(0, 1, 0, 4'd3, 0, 0, 0, "wrap_up_3");
        cyc(0, 1, 0, 4'd6, 0, 0, 0, "wrap_up_6");
        cyc(0, 1, 0, 4'd9, 0, 0, 0, "wrap_up_9_exact");
        cyc(0, 1, 0, 4'd2, 1, 0, 0, "wrap_up_2_wrapped");
        cyc(0, 1, 0, 4'd5, 0, 0, 0, "wrap_up_5_pulse_end");

        // Wrap down
        up_down = 1'b0;
        cyc(1, 0, 4'd2, 4'd2, 0, 0, 0, "wrap_dn_load2");
        cyc(0, 1, 0, 4'd9, 1, 0, 0, "wrap_dn_9_wrapped");
        cyc(0, 1, 0, 4'd6, 0, 0, 0, "wrap_dn_6");
        cyc(0, 1, 0, 4'd3, 0, 0, 0, "wrap_dn_3");
        cyc(0, 1, 0, 4'd0, 0, 0, 0, "wrap_dn_0_exact");
        cyc(0, 1, 0, 4'd7, 1, 0, 0, "wrap_dn_7_wrapped");

        // Saturate
        mode = 2'b01; step = 4'd4; up_down = 1'b1;
        cyc(1, 0, 4'd0, 4'd0, 0, 0, 0, "sat_load0");
        cyc(0, 1, 0, 4'd4, 0, 0, 0, "sat_up_4");
        cyc(0, 1, 0, 4'd8, 0, 0, 0, "sat_up_8");
        cyc(0, 1, 0, 4'd9, 0, 1, 0, "sat_up_clip");
        cyc(0, 1, 0, 4'd9, 0, 1, 0, "sat_up_hold");
        up_down = 1'b0;
        cyc(0, 1, 0, 4'd5, 0, 0, 0, "sat_dn_release");

        // One-shot
        mode = 2'b10; step = 4'd3; up_down = 1'b1;
        cyc(1, 0, 4'd0, 4'd0, 0, 0, 0, "os_load0");
        cyc(0, 1, 0, 4'd3, 0, 0, 0, "os_3");
        cyc(0, 1, 0, 4'd6, 0, 0, 0, "os_6");
        cyc(0, 1, 0, 4'd9, 0, 0, 1, "os_done");
        cyc(0, 1, 0, 4'd9, 0, 0, 1, "os_hold");
        mode = 2'b00;
        cyc(0, 0, 0, 4'd9, 0, 0, 1, "os_done_across_mode");
        mode = 2'b10;
        cyc(1, 0, 4'd15, 4'd9, 0, 0, 0, "os_load_clamp");

        // Priority, then limit lowered below count
        mode = 2'b00;
        cyc(1, 1, 4'd4, 4'd4, 0, 0, 0, "load_beats_enable");
        limit = 4'd2;
        cyc(0, 1, 0, 4'd0, 1, 0, 0, "limit_below_wrap_up");

        // limit = 0 pins count, wrap pulses every step
        limit = 4'd0;
        cyc(0, 1, 0, 4'd0, 1, 0, 0, "limit0_a");
        cyc(0, 1, 0, 4'd0, 1, 0, 0, "limit0_b");

        // step > limit behaves as step = limit
        limit = 4'd9; step = 4'd15;
        cyc(1, 0, 4'd0, 4'd0, 0, 0, 0, "bigstep_load0");
        cyc(0, 1, 0, 4'd9, 0, 0, 0, "bigstep_9");
        cyc(0, 1, 0, 4'd8, 1, 0, 0, "bigstep_wrap_8");

        // Hold mode and zero step
        mode = 2'b11;
        cyc(0, 1, 0, 4'd8, 0, 0, 0, "mode_hold");
        mode = 2'b00; step = 4'd0;
        cyc(0, 1, 0, 4'd8, 0, 0, 0, "step_zero");

        // Saturate down, exact landing on 0
        mode = 2'b01; step = 4'd3; up_down = 1'b0;
        cyc(1, 0, 4'd3, 4'd3, 0, 0, 0, "satdn_load3");
        cyc(0, 1, 0, 4'd0, 0, 1, 0, "satdn_exact0");
        cyc(0, 1, 0, 4'd0, 0, 1, 0, "satdn_clip0");
        up_down = 1'b1;
        cyc(0, 1, 0, 4'd3, 0, 0, 0, "satdn_release");

        // limit lowered below count: saturate up and plain down
        cyc(1, 0, 4'd7, 4'd7, 0, 0, 0, "lowlim_load7a");
        limit = 4'd4;
        cyc(0, 1, 0, 4'd4, 0, 1, 0, "lowlim_sat_up");
        limit = 4'd9;
        cyc(1, 0, 4'd7, 4'd7, 0, 0, 0, "lowlim_load7b");
        limit = 4'd4; up_down = 1'b0;
        cyc(0, 1, 0, 4'd4, 0, 0, 0, "lowlim_down");

        // Async reset between edges at count 6
        limit = 4'd9; mode = 2'b00; up_down = 1'b1;
        cyc(1, 0, 4'd3, 4'd3, 0, 0, 0, "ar_load3");
        cyc(0, 1, 0, 4'd6, 0, 0, 0, "ar_count6");
        @(negedge clk);
        load = 1'b0; enable = 1'b0;
        #1 res_n = 1'b0;
        #1 expect_now(4'd0, 0, 0, 0, "async_reset_mid_cycle");
        #1 res_n = 1'b1;
        @(posedge clk);
        #1 expect_now(4'd0, 0, 0, 0, "async_reset_after_edge");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
